// File: rtl/kf8259_in_service_control.sv
// kf8259_in_service_control
// Interrupt acknowledge sequencer for an 8259-style controller: raises INT,
// runs the two-pulse INTA handshake, drives the vector byte, and maintains
// the In-Service Register including specific, non-specific and automatic EOI.
module kf8259_in_service_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       eoi_nonspecific,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] clear_irr,
    output logic [7:0] in_service_register,
    output logic [7:0] vector,
    output logic       vector_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK1,
        ST_ACK2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic       r_inta_q;
    logic       w_inta_fall;
    logic       w_inta_rise;

    logic       w_first_ack;
    logic       w_second_ack;
    logic       w_ack_done;

    logic       w_irq_any;
    logic [2:0] w_irq_idx;

    logic [2:0] r_idx;
    logic       r_spurious;
    logic       r_int_out;
    logic [7:0] r_clear_irr;
    logic [7:0] r_isr;
    logic [7:0] r_vector;
    logic       r_vector_valid;

    logic [7:0] w_set_mask;
    logic [7:0] w_eoi_ns_mask;
    logic [7:0] w_eoi_sp_mask;
    logic [7:0] w_aeoi_mask;
    logic [7:0] w_clear_mask;

    assign w_inta_fall = r_inta_q & ~inta_n;
    assign w_inta_rise = ~r_inta_q & inta_n;
    assign w_irq_any   = |interrupt;

    // Register the acknowledge strobe for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inta_q <= 1'b1;
        end else begin
            r_inta_q <= inta_n;
        end
    end

    // Priority encode the request: lowest index wins, 7 when nothing requests
    always_comb begin
        w_irq_idx = 3'd7;
        for (int unsigned i = 0; i < 8; i++) begin
            if (interrupt[7 - i]) begin
                w_irq_idx = 3'(7 - i);
            end
        end
    end

    // Next-state decode for the acknowledge handshake
    always_comb begin
        w_state_next = r_state;
        w_first_ack  = 1'b0;
        w_second_ack = 1'b0;
        w_ack_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_inta_fall) begin
                    w_first_ack  = 1'b1;
                    w_state_next = ST_ACK1;
                end else if (w_irq_any) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_inta_fall) begin
                    w_first_ack  = 1'b1;
                    w_state_next = ST_ACK1;
                end
            end
            ST_ACK1: begin
                if (w_inta_fall) begin
                    w_second_ack = 1'b1;
                    w_state_next = ST_ACK2;
                end
            end
            ST_ACK2: begin
                if (w_inta_rise) begin
                    w_ack_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // INT is high exactly while the handshake is waiting for the first INTA
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_int_out <= 1'b0;
        end else begin
            r_int_out <= (w_state_next == ST_REQ);
        end
    end

    // Capture the acknowledged level and whether the acknowledge was spurious
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx      <= 3'd0;
            r_spurious <= 1'b0;
        end else if (w_first_ack) begin
            r_idx      <= w_irq_idx;
            r_spurious <= ~w_irq_any;
        end
    end

    // Set mask isolates the lowest requesting bit; empty on a spurious acknowledge
    assign w_set_mask    = w_first_ack ? (interrupt & (~interrupt + 8'd1)) : '0;
    // Lowest set ISR bit via two's-complement isolation; zero when ISR is empty
    assign w_eoi_ns_mask = eoi_nonspecific ? (r_isr & (~r_isr + 8'd1)) : '0;
    assign w_eoi_sp_mask = eoi_specific ? (8'd1 << eoi_level) : '0;
    assign w_aeoi_mask   = (w_ack_done && auto_eoi && !r_spurious) ? (8'd1 << r_idx) : '0;
    assign w_clear_mask  = w_eoi_ns_mask | w_eoi_sp_mask | w_aeoi_mask;

    // One-cycle IRR clear pulse for the acknowledged level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clear_irr <= '0;
        end else begin
            r_clear_irr <= w_set_mask;
        end
    end

    // In-Service Register: clears apply first so a same-cycle set wins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_isr <= '0;
        end else begin
            r_isr <= (r_isr & ~w_clear_mask) | w_set_mask;
        end
    end

    // Vector byte is loaded on the second INTA and held afterwards
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vector       <= '0;
            r_vector_valid <= 1'b0;
        end else if (w_second_ack) begin
            r_vector       <= {vector_base, r_idx};
            r_vector_valid <= 1'b1;
        end else if (w_ack_done) begin
            r_vector_valid <= 1'b0;
        end
    end

    assign int_out             = r_int_out;
    assign clear_irr           = r_clear_irr;
    assign in_service_register = r_isr;
    assign vector              = r_vector;
    assign vector_valid        = r_vector_valid;

endmodule

// File: tb/tb_kf8259_in_service_control.sv
// Testbench for kf8259_in_service_control: directed scenarios followed by
// random stimulus, all compared cycle by cycle with a behavioural model.
module tb_kf8259_in_service_control;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] interrupt;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       eoi_nonspecific;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] clear_irr;
    logic [7:0] in_service_register;
    logic [7:0] vector;
    logic       vector_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: stage counts progress through the acknowledge
    // (0 quiet, 1 INT raised, 2 one INTA seen, 3 two INTAs seen)
    bit       m_inta_prev;
    int       m_stage;
    bit [7:0] m_isr;
    int       m_idx;
    bit       m_spur;
    bit [7:0] m_vec;
    bit       m_vvalid;
    bit [7:0] m_clr;
    bit       m_int;

    kf8259_in_service_control dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .interrupt           (interrupt),
        .inta_n              (inta_n),
        .vector_base         (vector_base),
        .auto_eoi            (auto_eoi),
        .eoi_nonspecific     (eoi_nonspecific),
        .eoi_specific        (eoi_specific),
        .eoi_level           (eoi_level),
        .int_out             (int_out),
        .clear_irr           (clear_irr),
        .in_service_register (in_service_register),
        .vector              (vector),
        .vector_valid        (vector_valid)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_inta_prev = 1'b1;
        m_stage     = 0;
        m_isr       = '0;
        m_idx       = 0;
        m_spur      = 1'b0;
        m_vec       = '0;
        m_vvalid    = 1'b0;
        m_clr       = '0;
        m_int       = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit       fall;
        bit       rise;
        int       sel;
        int       set_bit;
        int       k;
        bit [7:0] nisr;
        fall    = m_inta_prev && !inta_n;
        rise    = !m_inta_prev && inta_n;
        sel     = lowest(interrupt);
        set_bit = -1;
        nisr    = m_isr;
        m_clr   = '0;
        if (eoi_nonspecific) begin
            k = lowest(m_isr);
            if (k >= 0) nisr[k] = 1'b0;
        end
        if (eoi_specific) nisr[eoi_level] = 1'b0;
        if (m_stage == 0 || m_stage == 1) begin
            if (fall) begin
                m_spur  = (sel < 0);
                m_idx   = (sel < 0) ? 7 : sel;
                set_bit = sel;
                m_stage = 2;
            end else if (m_stage == 0 && interrupt != 8'h00) begin
                m_stage = 1;
            end
        end else if (m_stage == 2) begin
            if (fall) begin
                m_vec    = 8'(int'(vector_base) * 8 + m_idx);
                m_vvalid = 1'b1;
                m_stage  = 3;
            end
        end else begin
            if (rise) begin
                if (auto_eoi && !m_spur) nisr[m_idx] = 1'b0;
                m_vvalid = 1'b0;
                m_stage  = 0;
            end
        end
        if (set_bit >= 0) begin
            nisr[set_bit]  = 1'b1;
            m_clr[set_bit] = 1'b1;
        end
        m_isr       = nisr;
        m_int       = (m_stage == 1);
        m_inta_prev = inta_n;
    endtask

    task automatic compare_all();
        check_eq("int_out", int_out, m_int);
        check_eq("clear_irr", clear_irr, m_clr);
        check_eq("isr", in_service_register, m_isr);
        check_eq("vector_valid", vector_valid, m_vvalid);
        check_eq("vector", vector, m_vec);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic run_ack(input logic [7:0] irq);
        interrupt = irq;
        tick();
        inta_n = 1'b0;
        tick();
        interrupt = '0;
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n         = 1'b0;
        interrupt       = '0;
        inta_n          = 1'b1;
        vector_base     = '0;
        auto_eoi        = 1'b0;
        eoi_nonspecific = 1'b0;
        eoi_specific    = 1'b0;
        eoi_level       = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        check_eq("reset_isr", in_service_register, 8'h00);
        reset_n = 1'b1;
        tick();

        // Basic acknowledge
        vector_base = 5'b01000;
        interrupt   = 8'h04;
        tick();
        check_eq("basic_int", int_out, 1'b1);
        inta_n = 1'b0;
        tick();
        check_eq("basic_clr", clear_irr, 8'h04);
        check_eq("basic_isr", in_service_register, 8'h04);
        interrupt = '0;
        inta_n = 1'b1;
        tick();
        check_eq("basic_clr_pulse", clear_irr, 8'h00);
        inta_n = 1'b0;
        tick();
        check_eq("basic_vec", vector, 8'h42);
        check_eq("basic_vvalid", vector_valid, 1'b1);
        inta_n = 1'b1;
        tick();
        check_eq("basic_vvalid_end", vector_valid, 1'b0);
        check_eq("basic_isr_hold", in_service_register, 8'h04);

        // Automatic EOI
        auto_eoi = 1'b1;
        run_ack(8'h04);
        check_eq("aeoi_isr", in_service_register, 8'h00);

        // Spurious acknowledge
        vector_base = 5'b00001;
        interrupt   = 8'h10;
        tick();
        interrupt = '0;
        tick();
        check_eq("spur_int_hold", int_out, 1'b1);
        inta_n = 1'b0;
        tick();
        check_eq("spur_clr", clear_irr, 8'h00);
        check_eq("spur_isr", in_service_register, 8'h00);
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        check_eq("spur_vec", vector, 8'h0F);
        inta_n = 1'b1;
        tick();
        check_eq("spur_isr_end", in_service_register, 8'h00);

        // EOI commands
        auto_eoi    = 1'b0;
        vector_base = '0;
        run_ack(8'h08);
        run_ack(8'h02);
        check_eq("eoi_setup", in_service_register, 8'h0A);
        eoi_nonspecific = 1'b1;
        tick();
        eoi_nonspecific = 1'b0;
        check_eq("eoi_ns", in_service_register, 8'h08);
        eoi_specific = 1'b1;
        eoi_level    = 3'd3;
        tick();
        eoi_specific = 1'b0;
        check_eq("eoi_sp", in_service_register, 8'h00);
        eoi_nonspecific = 1'b1;
        tick();
        eoi_nonspecific = 1'b0;
        check_eq("eoi_ns_empty", in_service_register, 8'h00);

        // Set and specific EOI of the same bit in one cycle
        interrupt = 8'h02;
        tick();
        inta_n       = 1'b0;
        eoi_specific = 1'b1;
        eoi_level    = 3'd1;
        tick();
        eoi_specific = 1'b0;
        check_eq("collide_isr", in_service_register, 8'h02);
        interrupt = '0;
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();

        // Multiple requests: lowest index taken
        interrupt = 8'h88;
        tick();
        inta_n = 1'b0;
        tick();
        check_eq("multi_clr", clear_irr, 8'h08);
        interrupt = '0;
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        check_eq("multi_vec", vector, 8'h03);
        inta_n = 1'b1;
        tick();
        check_eq("multi_isr", in_service_register, 8'h0A);

        // Reset while in the second acknowledge pulse
        vector_base = 5'b10101;
        interrupt   = 8'h01;
        tick();
        inta_n = 1'b0;
        tick();
        interrupt = '0;
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        check_eq("rst_pre_vvalid", vector_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_int", int_out, 1'b0);
        check_eq("rst_clr", clear_irr, 8'h00);
        check_eq("rst_isr", in_service_register, 8'h00);
        check_eq("rst_vec", vector, 8'h00);
        check_eq("rst_vvalid", vector_valid, 1'b0);
        inta_n = 1'b1;
        @(posedge clock);
        #1;
        compare_all();
        reset_n = 1'b1;
        repeat (3) tick();
        check_eq("rst_after_vvalid", vector_valid, 1'b0);
        check_eq("rst_after_int", int_out, 1'b0);
        run_ack(8'h20);
        check_eq("rst_recover_vec", vector, 8'hAD);

        // Random stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 7);
            if (r < 3)      interrupt = '0;
            else if (r < 6) interrupt = 8'(1 << $urandom_range(0, 7));
            else            interrupt = 8'($urandom);
            if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
            eoi_nonspecific = ($urandom_range(0, 7) == 0);
            eoi_specific    = ($urandom_range(0, 7) == 0);
            eoi_level       = 3'($urandom);
            if ($urandom_range(0, 15) == 0) auto_eoi = ~auto_eoi;
            if ($urandom_range(0, 49) == 0) vector_base = 5'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
